save_msx_config: RTL and testbench

Writes the slot-configuration table back into the DDR3 config image, using the same block format that the config loader parses. It emits a 16-byte "MSX" header for every populated table entry, at the address just before that entry's payload. It can optionally append a zero terminator after the last payload. It sits beside the config loader on the DDR3 byte port and runs when the menu commits an edited configuration before the image is uploaded or saved.

---
 rtl/save_msx_config_pkg.sv | 50 +++++
 rtl/save_msx_config_header_byte.sv | 31 +++
 rtl/save_msx_config.sv | 166 ++++++++++++++++
 tb/tb_save_msx_config.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/save_msx_config_pkg.sv
// Shared MSX slot-configuration types, header length and the payload-length rule
// used by both the config loader and the config writer.
package MSX;

  localparam int MAX_CONFIG  = 16;
  localparam int MSX_HDR_LEN = 16;

  typedef enum logic [7:0] {
    CONFIG_NONE       = 8'd0,
    CONFIG_RAM        = 8'd1,
    CONFIG_RAM_MAPPER = 8'd2,
    CONFIG_ROM_MIRROR = 8'd3,
    CONFIG_IO_MIRROR  = 8'd4,
    CONFIG_MIRROR     = 8'd5,
    CONFIG_KBD_LAYOUT = 8'd6,
    CONFIG_ROM        = 8'd7,
    CONFIG_FM_PAC     = 8'd8,
    CONFIG_CART       = 8'd9
  } config_typ_t;

  typedef struct packed {
    config_typ_t typ;
    logic [1:0]  slot;
    logic [1:0]  sub_slot;
    logic [7:0]  start_block;
    logic [3:0]  reference;
    logic [7:0]  block_count;
    logic [27:0] store_address;
  } msx_config_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_PORT = 3'd1,
    S_HEADER    = 3'd2,
    S_NEXT      = 3'd3,
    S_TERM      = 3'd4,
    S_DONE      = 3'd5
  } save_state_t;

  // Mirrors and RAM carry no payload in the image; blocks are 16 KiB each.
  function automatic logic [27:0] payload_len(config_typ_t typ, logic [7:0] block_count);
    case (typ)
      CONFIG_RAM, CONFIG_RAM_MAPPER, CONFIG_ROM_MIRROR,
      CONFIG_IO_MIRROR, CONFIG_MIRROR: payload_len = 28'd0;
      CONFIG_KBD_LAYOUT:               payload_len = 28'h200;
      default:                         payload_len = {6'd0, block_count, 14'd0};
    endcase
  endfunction

endpackage

// File: rtl/save_msx_config_header_byte.sv
// Combinational selector for one byte of the 16-byte "MSX" block header.
module msx_config_header_byte
  import MSX::*;
(
  input  msx_config_t entry,
  input  logic [1:0]  msx_type,
  input  logic [3:0]  byte_idx,
  output logic [7:0]  hdr_byte
);

  // The store address only positions the header; it is never part of its content.
  logic [27:0] unused_store;
  assign unused_store = entry.store_address;

  always_comb begin
    case (byte_idx)
      4'd0:    hdr_byte = 8'h4D;
      4'd1:    hdr_byte = 8'h53;
      4'd2:    hdr_byte = 8'h58;
      4'd3:    hdr_byte = {6'd0, msx_type};
      4'd4:    hdr_byte = {6'd0, entry.slot};
      4'd5:    hdr_byte = {6'd0, entry.sub_slot};
      4'd6:    hdr_byte = entry.start_block;
      4'd7:    hdr_byte = entry.typ;
      4'd8:    hdr_byte = {4'd0, entry.reference};
      4'd9:    hdr_byte = entry.block_count;
      default: hdr_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/save_msx_config.sv
// Serialises the slot-configuration table into MSX header blocks over the DDR3 byte port.
// Optional zero terminator block: define SAVE_MSX_CONFIG_TERMINATOR_EN.
module save_msx_config
  import MSX::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              save_request,
  input  logic [1:0]        msx_type,
  input  msx_config_t       msx_config [MAX_CONFIG],
  input  logic              ddr3_ready,
  output logic [27:0]       ddr3_addr,
  output logic [7:0]        ddr3_din,
  output logic              ddr3_wr,
  output logic              ddr3_request,
  output logic              save_busy,
  output logic              save_done,
  output logic [27:0]       image_size
);

  localparam logic [3:0] LAST_IDX = 4'(MAX_CONFIG - 1);

  save_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d, byte_q, byte_d;
  logic [27:0] end_q, end_d, addr_q, addr_d, size_q, size_d;
  logic [7:0]  din_q, din_d;
  logic        wr_q, wr_d, req_q, busy_d, done_q, done_d, abort_q;

  msx_config_t entry_s;
  logic [7:0]  hdr_byte_s;
  logic [27:0] hdr_end_s;
  logic        issue_s, ack_s;

  assign entry_s   = msx_config[cnt_q];
  assign hdr_end_s = entry_s.store_address + payload_len(entry_s.typ, entry_s.block_count);
  assign issue_s   = ddr3_ready && !wr_q;
  assign ack_s     = ddr3_ready && wr_q;

  msx_config_header_byte u_hdr (
    .entry    (entry_s),
    .msx_type (msx_type),
    .byte_idx (byte_q),
    .hdr_byte (hdr_byte_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    end_d   = end_q;
    addr_d  = addr_q;
    din_d   = din_q;
    wr_d    = wr_q;
    size_d  = size_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (save_request) begin
          cnt_d   = 4'd0;
          byte_d  = 4'd0;
          end_d   = 28'd0;
          state_d = S_WAIT_PORT;
        end
      end
      S_WAIT_PORT: begin
        if (ddr3_ready) begin
          byte_d  = 4'd0;
          state_d = S_HEADER;
        end
      end
      S_HEADER: begin
        if (entry_s.typ == CONFIG_NONE) begin
          state_d = S_NEXT;
        end else if (ack_s) begin
          wr_d = 1'b0;
          if (byte_q == 4'hF) begin
            byte_d  = 4'd0;
            state_d = S_NEXT;
            if (hdr_end_s > end_q) end_d = hdr_end_s;
          end else begin
            byte_d = byte_q + 4'd1;
          end
        end else if (issue_s) begin
          wr_d   = 1'b1;
          addr_d = entry_s.store_address - 28'(MSX_HDR_LEN) + {24'd0, byte_q};
          din_d  = hdr_byte_s;
        end
      end
      S_NEXT: begin
        if (cnt_q == LAST_IDX) begin
`ifdef SAVE_MSX_CONFIG_TERMINATOR_EN
          state_d = S_TERM;
`else
          state_d = S_DONE;
`endif
        end else begin
          cnt_d   = cnt_q + 4'd1;
          state_d = S_WAIT_PORT;
        end
      end
`ifdef SAVE_MSX_CONFIG_TERMINATOR_EN
      S_TERM: begin
        if (ack_s) begin
          wr_d = 1'b0;
          if (byte_q == 4'hF) begin
            byte_d  = 4'd0;
            end_d   = end_q + 28'(MSX_HDR_LEN);
            state_d = S_DONE;
          end else begin
            byte_d = byte_q + 4'd1;
          end
        end else if (issue_s) begin
          wr_d   = 1'b1;
          addr_d = end_q + {24'd0, byte_q};
          din_d  = 8'h00;
        end
      end
`endif
      S_DONE: begin
        size_d  = end_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // A reset that aborts a save leaves the last published image_size intact.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      byte_q  <= 4'd0;
      end_q   <= 28'd0;
      addr_q  <= 28'd0;
      din_q   <= 8'h00;
      wr_q    <= 1'b0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= req_q | abort_q;
      if (!(req_q | abort_q)) size_q <= 28'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      end_q   <= end_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      wr_q    <= wr_d;
      req_q   <= busy_d;
      done_q  <= done_d;
      size_q  <= size_d;
      abort_q <= 1'b0;
    end
  end

  assign ddr3_addr    = addr_q;
  assign ddr3_din     = din_q;
  assign ddr3_wr      = wr_q;
  assign ddr3_request = req_q;
  assign save_busy    = req_q;
  assign save_done    = done_q;
  assign image_size   = size_q;

endmodule

// File: tb/tb_save_msx_config.sv
// Directed and randomized bench for save_msx_config against a write-list reference model.
module tb_save_msx_config;
  import MSX::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, save_request, ddr3_ready;
  logic [1:0]  msx_type;
  msx_config_t cfg [MAX_CONFIG];
  logic [27:0] ddr3_addr, image_size;
  logic [7:0]  ddr3_din;
  logic        ddr3_wr, ddr3_request, save_busy, save_done;

  save_msx_config dut (
    .clk(clk), .reset_n(reset_n), .save_request(save_request), .msx_type(msx_type),
    .msx_config(cfg), .ddr3_ready(ddr3_ready), .ddr3_addr(ddr3_addr), .ddr3_din(ddr3_din),
    .ddr3_wr(ddr3_wr), .ddr3_request(ddr3_request), .save_busy(save_busy),
    .save_done(save_done), .image_size(image_size)
  );

  int total = 0, bad = 0;
  int stab_err = 0, done_cnt = 0;
  logic [35:0] exp_q[$], got_q[$];
  logic [27:0] exp_size, prior_size;
  logic        prev_wr = 1'b0;
  logic [35:0] prev_ad = 36'd0;

  // Mid-cycle monitor: records each acknowledged byte and checks hold-stability.
  always @(negedge clk) begin
    if (reset_n && ddr3_wr) begin
      if (prev_wr && ({ddr3_addr, ddr3_din} !== prev_ad)) stab_err <= stab_err + 1;
      if (ddr3_ready) got_q.push_back({ddr3_addr, ddr3_din});
    end
    prev_wr <= reset_n && ddr3_wr && !ddr3_ready;
    prev_ad <= {ddr3_addr, ddr3_din};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: list every byte the image should receive, in order, plus final size.
  task automatic build_model();
    logic [27:0] e, plen, base;
    logic [7:0]  hb [16];
    int          t;
    exp_q.delete();
    e = 28'd0;
    for (int i = 0; i < MAX_CONFIG; i++) begin
      t = int'(cfg[i].typ);
      if (t != 0) begin
        foreach (hb[k]) hb[k] = 8'h00;
        hb[0] = 8'h4D; hb[1] = 8'h53; hb[2] = 8'h58;
        hb[3] = {6'd0, msx_type};
        hb[4] = {6'd0, cfg[i].slot};
        hb[5] = {6'd0, cfg[i].sub_slot};
        hb[6] = cfg[i].start_block;
        hb[7] = 8'(t);
        hb[8] = {4'd0, cfg[i].reference};
        hb[9] = cfg[i].block_count;
        base = cfg[i].store_address - 28'd16;
        for (int b = 0; b < 16; b++) exp_q.push_back({base + 28'(b), hb[b]});
        if (t >= 1 && t <= 5) plen = 28'd0;
        else if (t == 6) plen = 28'd512;
        else plen = 28'(cfg[i].block_count) * 28'd16384;
        if (cfg[i].store_address + plen > e) e = cfg[i].store_address + plen;
      end
    end
`ifdef SAVE_MSX_CONFIG_TERMINATOR_EN
    for (int b = 0; b < 16; b++) exp_q.push_back({e + 28'(b), 8'h00});
    e = e + 28'd16;
`endif
    exp_size = e;
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < MAX_CONFIG; i++) cfg[i] = '0;
  endtask

  task automatic random_cfg();
    for (int i = 0; i < MAX_CONFIG; i++) begin
      cfg[i].typ           = ($urandom_range(0, 1) == 0) ? CONFIG_NONE
                                                         : config_typ_t'(8'($urandom_range(1, 9)));
      cfg[i].slot          = 2'($urandom);
      cfg[i].sub_slot      = 2'($urandom);
      cfg[i].start_block   = 8'($urandom);
      cfg[i].reference     = 4'($urandom);
      cfg[i].block_count   = 8'($urandom);
      cfg[i].store_address = 28'($urandom);
    end
  endtask

  // mode 0: ready high; 1: random ready; 2: one 5-cycle stall while byte 5 is on the bus.
  task automatic run_save(input int mode, input bit again);
    int cyc, extra, stall_left;
    bit stalled;
    build_model();
    got_q.delete();
    stab_err = 0;
    done_cnt = 0;
    @(posedge clk); #1;
    save_request = 1'b1;
    ddr3_ready   = 1'b1;
    @(posedge clk); #1;
    save_request = 1'b0;
    check("busy_latency", save_busy, 1);
    check("request_on", ddr3_request, 1);
    cyc = 0; extra = -1; stall_left = 0; stalled = 0;
    while (extra != 0 && cyc < 20000) begin
      if (mode == 2 && !stalled && ddr3_wr && got_q.size() == 5) begin
        stalled    = 1;
        stall_left = 5;
      end
      if (stall_left > 0) begin
        ddr3_ready = 1'b0;
        stall_left--;
      end else if (mode == 1) ddr3_ready = ($urandom_range(0, 2) != 0);
      else ddr3_ready = 1'b1;
      save_request = again && (cyc == 12);
      @(posedge clk); #1;
      cyc++;
      if (save_done) begin
        done_cnt++;
        if (extra < 0) extra = 4;
      end
      if (extra > 0) extra--;
    end
    save_request = 1'b0;
    ddr3_ready   = 1'b1;
    check("timeout", cyc < 20000, 1);
    check("done_count", done_cnt, 1);
    check("write_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("write[%0d]", i), got_q[i], exp_q[i]);
    check("image_size", image_size, exp_size);
    check("hold_stable", stab_err, 0);
    check("busy_off", save_busy, 0);
    check("request_off", ddr3_request, 0);
  endtask

  initial begin
    int cyc;
    reset_n = 1'b0; save_request = 1'b0; ddr3_ready = 1'b1; msx_type = 2'd0;
    clear_cfg();
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr", ddr3_wr, 0);
    check("rst_request", ddr3_request, 0);
    check("rst_busy", save_busy, 0);
    check("rst_done", save_done, 0);
    check("rst_size", image_size, 0);
    check("rst_addr", ddr3_addr, 0);
    check("rst_din", ddr3_din, 0);
    reset_n = 1'b1;

    // Single ROM entry
    msx_type = 2'd1;
    cfg[0] = '{typ: CONFIG_ROM, slot: 2'd1, sub_slot: 2'd2, start_block: 8'd0, reference: 4'd3,
               block_count: 8'd2, store_address: 28'h10};
    run_save(0, 0);
    check("rom_b0", got_q[0], {28'h0, 8'h4D});
    check("rom_b3", got_q[3], {28'h3, 8'h01});
    check("rom_b7", got_q[7], {28'h7, 8'h07});
    check("rom_b9", got_q[9], {28'h9, 8'h02});
`ifdef SAVE_MSX_CONFIG_TERMINATOR_EN
    check("rom_size", image_size, 28'h8020);
    check("rom_term", got_q[16], {28'h8010, 8'h00});
`else
    check("rom_size", image_size, 28'h8010);
`endif

    // All entries NONE
    clear_cfg();
    run_save(0, 0);
`ifdef SAVE_MSX_CONFIG_TERMINATOR_EN
    check("none_size", image_size, 28'h10);
`else
    check("none_size", image_size, 28'h0);
`endif

    // KBD_LAYOUT then RAM
    cfg[0] = '{typ: CONFIG_KBD_LAYOUT, slot: 2'd0, sub_slot: 2'd0, start_block: 8'd0,
               reference: 4'd0, block_count: 8'd0, store_address: 28'h10};
    cfg[1] = '{typ: CONFIG_RAM, slot: 2'd3, sub_slot: 2'd1, start_block: 8'd0,
               reference: 4'd5, block_count: 8'd4, store_address: 28'h220};
    run_save(0, 0);
    check("kbd_hdr1_addr", got_q[16][35:8], 28'h210);
`ifdef SAVE_MSX_CONFIG_TERMINATOR_EN
    check("kbd_size", image_size, 28'h230);
`else
    check("kbd_size", image_size, 28'h220);
`endif

    // Stall mid-header, plus a second request while busy
    random_cfg();
    cfg[0].typ = CONFIG_CART;
    msx_type = 2'd3;
    run_save(2, 1);
    prior_size = exp_size;

    // Reset during byte 7 of entry 3
    clear_cfg();
    cfg[3] = '{typ: CONFIG_FM_PAC, slot: 2'd2, sub_slot: 2'd0, start_block: 8'd1,
               reference: 4'd9, block_count: 8'd1, store_address: 28'h4000};
    got_q.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    save_request = 1'b1;
    @(posedge clk); #1;
    save_request = 1'b0;
    cyc = 0;
    while (!(ddr3_wr && got_q.size() == 7) && cyc < 2000) begin
      @(posedge clk); #1;
      if (save_done) done_cnt++;
      cyc++;
    end
    check("reach_byte7", cyc < 2000, 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("abort_wr", ddr3_wr, 0);
    check("abort_request", ddr3_request, 0);
    check("abort_busy", save_busy, 0);
    @(posedge clk); #1;
    check("abort_size_hold", image_size, prior_size);
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (save_done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    run_save(0, 0);

    // Randomized tables with random ready
    repeat (6) begin
      random_cfg();
      msx_type = 2'($urandom);
      run_save(1, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
